// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-side control bundle between the pipeline datapath and the hazard controller.
// The master drives instruction/event inputs; the slave returns stall/flush/freeze.
interface pipeline_hazard_ctrl_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_branch_taken;
  logic        mem_busy;
  logic        stall_pc;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        flush_idex;
  logic        freeze;
  logic [1:0]  ctrl_state;

  modport master (
    output id_valid, id_instr, ex_branch_taken, mem_busy,
    input  stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, ctrl_state
  );

  modport slave (
    input  id_valid, id_instr, ex_branch_taken, mem_busy,
    output stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, ctrl_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / redirect / memory-wait sequencer beside ID; control outputs are
// combinational (zero-cycle), only state, bubble count and EX scoreboard are registered.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int REG_ADDR_W       = 5
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_e;

  state_e                state_q, state_d, saved_q, saved_d, eff_state;
  logic [1:0]            cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_is_load_q, ex_is_load_d;

  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  reads_rs1, reads_rs2, writes_rd, is_load, hazard;
  logic                  stall_pc_c, stall_ifid_c, flush_ifid_c, flush_idex_c, freeze_c;
  logic                  unused_instr;

  assign opcode       = bus.id_instr[6:0];
  assign rd           = bus.id_instr[7 +: REG_ADDR_W];
  assign rs1          = bus.id_instr[15 +: REG_ADDR_W];
  assign rs2          = bus.id_instr[20 +: REG_ADDR_W];
  assign unused_instr = ^bus.id_instr;

  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      7'b0110011: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; writes_rd = 1'b1; end
      7'b0100011,
      7'b1100011: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      7'b0010011,
      7'b1100111: begin reads_rs1 = 1'b1; writes_rd = 1'b1; end
      7'b0000011: begin reads_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
      7'b0110111,
      7'b0010111,
      7'b1101111: writes_rd = 1'b1;
      default: ;
    endcase
  end

  assign hazard = bus.id_valid && ex_is_load_q && (ex_rd_q != '0) &&
                  ((reads_rs1 && (rs1 == ex_rd_q)) || (reads_rs2 && (rs2 == ex_rd_q)));

  // Leaving FREEZE acts on the saved state in the same cycle mem_busy drops.
  assign eff_state = (state_q == ST_FREEZE) ? saved_q : state_q;

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    ex_rd_d      = '0;
    ex_is_load_d = 1'b0;
    stall_pc_c   = 1'b0;
    stall_ifid_c = 1'b0;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    freeze_c     = 1'b0;
    if (bus.mem_busy) begin
      freeze_c     = 1'b1;
      stall_pc_c   = 1'b1;
      stall_ifid_c = 1'b1;
      state_d      = ST_FREEZE;
      ex_rd_d      = ex_rd_q;
      ex_is_load_d = ex_is_load_q;
      if (state_q != ST_FREEZE) saved_d = state_q;
    end else if (bus.ex_branch_taken) begin
      flush_ifid_c = 1'b1;
      flush_idex_c = 1'b1;
      state_d      = ST_FLUSH;
      cnt_d        = 2'd0;
    end else begin
      case (eff_state)
        ST_FLUSH: begin
          flush_idex_c = 1'b1;
          state_d      = ST_RUN;
        end
        ST_STALL: begin
          stall_pc_c   = 1'b1;
          stall_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
          state_d = (cnt_q <= 2'd1) ? ST_RUN : ST_STALL;
        end
        default: begin
          state_d = ST_RUN;
          if (hazard) begin
            stall_pc_c   = 1'b1;
            stall_ifid_c = 1'b1;
            flush_idex_c = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_d = ST_STALL;
              cnt_d   = 2'(LOAD_USE_BUBBLES - 1);
            end
          end else if (bus.id_valid) begin
            ex_rd_d      = writes_rd ? rd : '0;
            ex_is_load_d = is_load;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      saved_q      <= ST_RUN;
      cnt_q        <= 2'd0;
      ex_rd_q      <= '0;
      ex_is_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      cnt_q        <= cnt_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign bus.stall_pc   = !rst && stall_pc_c;
  assign bus.stall_ifid = !rst && stall_ifid_c;
  assign bus.flush_ifid = !rst && flush_ifid_c;
  assign bus.flush_idex = !rst && flush_idex_c;
  assign bus.freeze     = !rst && freeze_c;
  assign bus.ctrl_state = rst ? 2'd0 : state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside the ID stage, decodes source and destination use from the ID instruction by opcode, and tracks the instruction issued into EX. It drives PC/IF-ID stall, IF-ID/ID-EX flush and a global freeze for load-use hazards, taken branch/jump redirects and data-memory wait.

Parameters:
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
REG_ADDR_W, 5, register address width.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID slot holds a live instruction
id_instr  in  32  instruction in ID
ex_branch_taken  in  1  branch/jal/jalr in EX resolved taken (redirect)
mem_busy  in  1  data memory not ready; pipeline must freeze
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID register
flush_ifid  out  1  kill IF/ID contents
flush_idex  out  1  load bubble (NOP) into ID/EX
freeze  out  1  hold every pipeline register (ID/EX, EX/MEM, MEM/WB included)
ctrl_state  out  2  current state: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE

Behaviour:
- Reset: synchronous, active-high. On rising clk with rst=1: state=RUN, bubble counter=0, scoreboard (ex_rd, ex_is_load) cleared, saved state=RUN. While rst=1, all outputs are 0 and ctrl_state=0.
- Opcode decode:
  - Reads rs1 and rs2: 0110011, 0100011, 1100011.
  - Reads rs1 only: 0010011, 0000011, 1100111.
  - Reads no sources: 0110111, 0010111, 1101111, unknown opcodes.
  - Writes rd: 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
  - Load: 0000011.
- Hazard: id_valid and ex_is_load and ex_rd != 0 and ex_rd equals a source field actually read.
- Issue: ID advances when id_valid=1, state is RUN, no hazard, and no higher-priority event. On issue: ex_rd = rd if the instruction writes rd, else 0; ex_is_load = load.
- On any bubble, flush or non-issue, the scoreboard is cleared to 0 (except under FREEZE).
- Priority, evaluated combinationally each cycle: mem_busy > ex_branch_taken > hazard/STALL > RUN.
- FREEZE:
  - Entered on any cycle with mem_busy=1. Outputs: freeze=1, stall_pc=1, stall_ifid=1; both flushes 0.
  - Counter, scoreboard and saved state are held. The pre-freeze state is saved on entry.
  - The cycle after mem_busy drops, the controller resumes the saved state.
  - ex_branch_taken is ignored while frozen; upstream holds it stable, so it is acted on after exit.
- Redirect: ex_branch_taken=1 and mem_busy=0, in any of RUN, STALL or FLUSH.
  - Same cycle: flush_ifid=1, flush_idex=1, stalls=0.
  - Next state FLUSH. Any pending STALL count is cancelled (counter=0).
- FLUSH (one cycle):
  - The ID slot is treated as invalid regardless of id_valid: no hazard check, no issue, stalls 0, flush_idex=1.
  - Next state RUN, unless redirect or freeze takes priority.
- RUN with hazard:
  - Same cycle: stall_pc=1, stall_ifid=1, flush_idex=1.
  - If LOAD_USE_BUBBLES=1, stay RUN (the scoreboard cleared by the bubble removes the hazard).
  - Otherwise go to STALL with counter=LOAD_USE_BUBBLES-1.
- STALL:
  - Outputs: stall_pc=1, stall_ifid=1, flush_idex=1.
  - Counter decrements each non-frozen cycle. At counter=1, the next state is RUN.
  - The counter never wraps below 0.
- Latency: all control outputs are combinational from current state and inputs, with zero-cycle response. Only state, counter, scoreboard and saved state are registered.
- Simultaneous events:
  - Hazard together with redirect: redirect wins.
  - Reset during STALL or FREEZE: returns to RUN, no residual stall.

Test Plan:
- Load-use, N=1: issue lw x5,0(x1) (0x0000A283), then ID=add x6,x5,x2 (0x00228333) -> 1 cycle of stall_pc=stall_ifid=flush_idex=1; add issues the next cycle; ctrl_state stays 0.
- No false hazard: lw x0,0(x1) (0x0000A003) then add reading x0, and separately lw x5 then lui x5,0 (0x000002B7) -> no stall in either case.
- Load-use, N=3: same lw/add pair -> 3 consecutive bubble cycles; ctrl_state sequence 0,1,1,0; add issues in cycle 4.
- Redirect during STALL (N=3): ex_branch_taken=1 in the second bubble cycle -> flush_ifid=flush_idex=1 that cycle, ctrl_state=2 next cycle, then 0; no further stall.
- Freeze: mem_busy=1 for 4 cycles in mid-STALL (counter=2) -> freeze=1 for those 4 cycles, counter held; remaining 2 bubbles complete after release. Also, ex_branch_taken asserted during freeze -> flush only after mem_busy=0.
- Reset: rst=1 for one cycle while in STALL or FREEZE -> all outputs 0 during rst, ctrl_state=0 after, scoreboard empty (a following add x6,x5,x2 does not stall).
